flag_producer: RTL and testbench

Producer side of the NZCV condition-flag path: derives N, Z, C, V from the execute-stage ALU/shifter outputs, holds them for one pending cycle, then commits them to the architectural flags register. The condition checker consumes that register. Sits between the execute-stage ALU and the condition checker. Provides masked partial updates, flush kill, and either flag forwarding or a decode stall for flag hazards.

---
 rtl/flag_producer_if.sv | 32 +++
 rtl/flag_producer.sv | 107 ++++++++++
 tb/tb_flag_producer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_producer_if.sv
// Execute-stage to flag-producer bundle: ALU/shifter results, flag-write controls,
// decode condition, and the committed/forwarded flag views returned to the pipeline.
interface flag_producer_if #(
   parameter int WIDTH = 32
);
   logic             ex_valid;
   logic [1:0]       ex_flagw;
   logic             ex_condex;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;
   logic             alu_vout;
   logic             alu_arith;
   logic             shift_cout;
   logic             flush;
   logic [3:0]       dec_cond;
   logic [3:0]       Flags;
   logic [3:0]       flags_fwd;
   logic             pending;
   logic             stall;

   modport master (
      output ex_valid, ex_flagw, ex_condex, alu_result, alu_cout, alu_vout,
             alu_arith, shift_cout, flush, dec_cond,
      input  Flags, flags_fwd, pending, stall
   );

   modport slave (
      input  ex_valid, ex_flagw, ex_condex, alu_result, alu_cout, alu_vout,
             alu_arith, shift_cout, flush, dec_cond,
      output Flags, flags_fwd, pending, stall
   );
endinterface

// File: rtl/flag_producer.sv
// NZCV producer: captures flags from execute, holds them one pending cycle, then commits.
// Build option FLAG_FWD_EN: forward pending flags to the checker instead of stalling decode.
module flag_producer #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           reset_n,
   flag_producer_if.slave bus
);
   localparam logic [3:0] COND_AL = 4'b1110;

   logic       p_valid_q, p_valid_d;
   logic [1:0] p_mask_q,  p_mask_d;
   logic [3:0] p_nzcv_q,  p_nzcv_d;
   logic [3:0] flags_q,   flags_d;
   logic       capture_s;
   logic [3:0] fwd_view_s;
   logic [3:0] cap_nzcv_s;
   logic [3:0] flags_fwd_s;
   logic       stall_s;

   function automatic logic [3:0] overlay(input logic [3:0] base,
                                          input logic [3:0] upd,
                                          input logic [1:0] mask);
      logic [3:0] r;
      r = base;
      if (mask[1]) begin
         r[3:2] = upd[3:2];
      end else begin
         r[3:2] = base[3:2];
      end
      if (mask[0]) begin
         r[1:0] = upd[1:0];
      end else begin
         r[1:0] = base[1:0];
      end
      return r;
   endfunction

   // Capture qualification, architectural view including the pending write, and new NZCV.
   always_comb begin
      capture_s  = bus.ex_valid & bus.ex_condex & (|bus.ex_flagw) & ~bus.flush;
      fwd_view_s = flags_q;
      if (p_valid_q) begin
         fwd_view_s = overlay(flags_q, p_nzcv_q, p_mask_q);
      end else begin
         fwd_view_s = flags_q;
      end
      // Logical ops keep V from the newest flags, which may still be pending.
      cap_nzcv_s[3] = bus.alu_result[WIDTH-1];
      cap_nzcv_s[2] = (bus.alu_result == '0);
      cap_nzcv_s[1] = bus.alu_arith ? bus.alu_cout : bus.shift_cout;
      cap_nzcv_s[0] = bus.alu_arith ? bus.alu_vout : fwd_view_s[0];
   end

   // Next-state: commit the pending write unless flushed, then load the new capture.
   always_comb begin
      flags_d   = flags_q;
      p_valid_d = capture_s;
      p_mask_d  = p_mask_q;
      p_nzcv_d  = p_nzcv_q;
      if (p_valid_q & ~bus.flush) begin
         flags_d = overlay(flags_q, p_nzcv_q, p_mask_q);
      end else begin
         flags_d = flags_q;
      end
      if (capture_s) begin
         p_mask_d = bus.ex_flagw;
         p_nzcv_d = cap_nzcv_s;
      end else begin
         p_mask_d = p_mask_q;
         p_nzcv_d = p_nzcv_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q   <= 4'b0000;
         p_valid_q <= 1'b0;
         p_mask_q  <= 2'b00;
         p_nzcv_q  <= 4'b0000;
      end else begin
         flags_q   <= flags_d;
         p_valid_q <= p_valid_d;
         p_mask_q  <= p_mask_d;
         p_nzcv_q  <= p_nzcv_d;
      end
   end

   // Checker view and decode hold depend on whether forwarding is built in.
   always_comb begin
`ifdef FLAG_FWD_EN
      flags_fwd_s = fwd_view_s;
      stall_s     = 1'b0;
`else
      flags_fwd_s = flags_q;
      stall_s     = reset_n & (bus.dec_cond != COND_AL) & capture_s;
`endif
   end

   assign bus.Flags     = flags_q;
   assign bus.pending   = p_valid_q;
   assign bus.flags_fwd = flags_fwd_s;
   assign bus.stall     = stall_s;

endmodule

// File: tb/tb_flag_producer.sv
// Self-checking bench for flag_producer: directed scenarios plus randomized traffic
// against an architectural model (in-flight write queue over committed flags).
module tb_flag_producer;
   localparam int         WIDTH = 32;
   localparam logic [3:0] AL    = 4'b1110;
`ifdef FLAG_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] mask;
      logic [3:0] nzcv;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   flag_producer_if #(.WIDTH(WIDTH)) bus ();
   flag_producer #(.WIDTH(WIDTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [3:0] apply_write(input logic [3:0] base, input wr_t w);
      logic [3:0] r;
      r = base;
      if (w.mask[1]) r[3:2] = w.nzcv[3:2];
      if (w.mask[0]) r[1:0] = w.nzcv[1:0];
      return r;
   endfunction

   task automatic drive(input logic v, input logic [1:0] fw, input logic cx,
                        input logic [31:0] res, input logic co, input logic vo,
                        input logic ar, input logic sc, input logic fl,
                        input logic [3:0] cond);
      bus.ex_valid   = v;
      bus.ex_flagw   = fw;
      bus.ex_condex  = cx;
      bus.alu_result = res;
      bus.alu_cout   = co;
      bus.alu_vout   = vo;
      bus.alu_arith  = ar;
      bus.shift_cout = sc;
      bus.flush      = fl;
      bus.dec_cond   = cond;
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AL);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      repeat (2) next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", bus.Flags); end
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", bus.pending); end
      checks++; if (bus.flags_fwd !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b want 0000", bus.flags_fwd); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      next();
      reset_n = 1'b1;
      next();
      drive(1'b1, 2'b11, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      next();
      idle();
      @(negedge clk);
      checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL midrst_pending_before: got %b want 1", bus.pending); end
      #1 reset_n = 1'b0;
      #1;
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL midrst_pending: got %b want 0", bus.pending); end
      checks++; if (bus.Flags !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b want 0000", bus.Flags); end
      checks++; if (bus.flags_fwd !== 4'b0000) begin errors++; $display("FAIL midrst_fwd: got %b want 0000", bus.flags_fwd); end
      next();
      @(negedge clk);
      #1 reset_n = 1'b1;
      next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b0000) begin errors++; $display("FAIL rst_release_flags: got %b want 0000", bus.Flags); end
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL rst_release_pending: got %b want 0", bus.pending); end
      next();
   endtask

   task automatic test_add_all_flags();
      drive(1'b1, 2'b11, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, AL);
      @(negedge clk);
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL add_stall_al: got %b want 0", bus.stall); end
      next();
      idle();
      @(negedge clk);
      checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL add_pending: got %b want 1", bus.pending); end
      checks++; if (bus.Flags !== 4'b0000) begin errors++; $display("FAIL add_flags_early: got %b want 0000", bus.Flags); end
      checks++; if (bus.flags_fwd !== (FWD ? 4'b0110 : 4'b0000)) begin errors++; $display("FAIL add_fwd_early: got %b want %b", bus.flags_fwd, (FWD ? 4'b0110 : 4'b0000)); end
      next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b0110) begin errors++; $display("FAIL add_flags: got %b want 0110", bus.Flags); end
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL add_pending_clear: got %b want 0", bus.pending); end
      checks++; if (bus.flags_fwd !== 4'b0110) begin errors++; $display("FAIL add_fwd: got %b want 0110", bus.flags_fwd); end
      next();
   endtask

   task automatic test_logical_v();
      drive(1'b1, 2'b11, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AL);
      next();
      idle();
      next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b0001) begin errors++; $display("FAIL logic_setup: got %b want 0001", bus.Flags); end
      next();
      drive(1'b1, 2'b11, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, AL);
      next();
      idle();
      next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b1011) begin errors++; $display("FAIL logic_vkeep: got %b want 1011", bus.Flags); end
      next();
   endtask

   task automatic test_partial_mask();
      drive(1'b1, 2'b10, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AL);
      next();
      idle();
      next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b0011) begin errors++; $display("FAIL partial_mask: got %b want 0011", bus.Flags); end
      next();
   endtask

   task automatic test_flush();
      drive(1'b1, 2'b11, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AL);
      next();
      idle();
      bus.flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL flush_pending_t1: got %b want 1", bus.pending); end
      next();
      idle();
      @(negedge clk);
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL flush_pending_t2: got %b want 0", bus.pending); end
      checks++; if (bus.Flags !== 4'b0011) begin errors++; $display("FAIL flush_flags: got %b want 0011", bus.Flags); end
      next();
      drive(1'b1, 2'b11, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
      @(negedge clk);
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_same_stall: got %b want 0", bus.stall); end
      next();
      idle();
      @(negedge clk);
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL flush_same_pending: got %b want 0", bus.pending); end
      next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b0011) begin errors++; $display("FAIL flush_same_flags: got %b want 0011", bus.Flags); end
      next();
   endtask

   task automatic test_hazard();
      drive(1'b1, 2'b11, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      checks++; if (bus.stall !== !FWD) begin errors++; $display("FAIL hazard_stall: got %b want %b", bus.stall, !FWD); end
      next();
      idle();
      bus.dec_cond = 4'b0000;
      @(negedge clk);
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL hazard_one_cycle: got %b want 0", bus.stall); end
      next();
      drive(1'b1, 2'b11, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AL);
      @(negedge clk);
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL hazard_al: got %b want 0", bus.stall); end
      next();
      drive(1'b1, 2'b11, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
      @(negedge clk);
      checks++; if (bus.stall !== !FWD) begin errors++; $display("FAIL hazard_nv: got %b want %b", bus.stall, !FWD); end
      next();
      idle();
      next();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'b11, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, AL);
      next();
      drive(1'b1, 2'b11, 1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AL);
      @(negedge clk);
      checks++; if (bus.flags_fwd !== (FWD ? 4'b0101 : 4'b0000)) begin errors++; $display("FAIL b2b_fwd1: got %b want %b", bus.flags_fwd, (FWD ? 4'b0101 : 4'b0000)); end
      next();
      idle();
      @(negedge clk);
      checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b want 1", bus.pending); end
      checks++; if (bus.Flags !== 4'b0101) begin errors++; $display("FAIL b2b_flags1: got %b want 0101", bus.Flags); end
      checks++; if (bus.flags_fwd !== (FWD ? 4'b0001 : 4'b0101)) begin errors++; $display("FAIL b2b_fwd2: got %b want %b", bus.flags_fwd, (FWD ? 4'b0001 : 4'b0101)); end
      next();
      @(negedge clk);
      checks++; if (bus.Flags !== 4'b0001) begin errors++; $display("FAIL b2b_flags2: got %b want 0001", bus.Flags); end
      next();
   endtask

   task automatic test_random();
      logic [3:0]  committed;
      logic [3:0]  arch;
      logic [3:0]  nzcv;
      logic [3:0]  exp_fwd;
      wr_t         inflight[$];
      wr_t         w;
      logic        v, cx, co, vo, ar, sc, fl, cap, exp_stall;
      logic [1:0]  fw;
      logic [31:0] res;
      logic [3:0]  cond;
      reset_n = 1'b0;
      idle();
      next();
      reset_n = 1'b1;
      committed = 4'b0000;
      inflight.delete();
      for (int i = 0; i < 400; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         fw   = 2'($urandom);
         cx   = ($urandom_range(0, 4) != 0);
         res  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
         co   = 1'($urandom);
         vo   = 1'($urandom);
         ar   = 1'($urandom);
         sc   = 1'($urandom);
         fl   = ($urandom_range(0, 7) == 0);
         cond = ($urandom_range(0, 2) == 0) ? AL : 4'($urandom);
         drive(v, fw, cx, res, co, vo, ar, sc, fl, cond);
         arch = committed;
         foreach (inflight[k]) arch = apply_write(arch, inflight[k]);
         cap       = v & cx & (|fw) & ~fl;
         exp_fwd   = FWD ? arch : committed;
         exp_stall = !FWD && cap && (cond != AL);
         @(negedge clk);
         checks++; if (bus.Flags !== committed) begin errors++; $display("FAIL rand_flags[%0d]: got %b want %b", i, bus.Flags, committed); end
         checks++; if (bus.pending !== (inflight.size() != 0)) begin errors++; $display("FAIL rand_pending[%0d]: got %b want %b", i, bus.pending, (inflight.size() != 0)); end
         checks++; if (bus.flags_fwd !== exp_fwd) begin errors++; $display("FAIL rand_fwd[%0d]: got %b want %b", i, bus.flags_fwd, exp_fwd); end
         checks++; if (bus.stall !== exp_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %b want %b", i, bus.stall, exp_stall); end
         nzcv = {res[31], (res == 32'h0), (ar ? co : sc), (ar ? vo : arch[0])};
         if (fl) inflight.delete();
         while (inflight.size() != 0) committed = apply_write(committed, inflight.pop_front());
         if (cap) begin
            w.mask = fw;
            w.nzcv = nzcv;
            inflight.push_back(w);
         end
         next();
      end
   endtask

   initial begin
      test_reset();
      test_add_all_flags();
      test_logical_v();
      test_partial_mask();
      test_flush();
      test_hazard();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
